csa_add_scheduler: RTL and testbench
====================================

# csa_add_scheduler

Multi-cycle adder scheduler that shares one 4-bit `Carry_skip_adder` slice between two requesters. It adds WIDTH-bit operands by feeding the slice one nibble per cycle, least significant nibble first, and registers the ripple carry between nibbles. It grants requesters round-robin, captures their operands, and returns the sum, carry-out and signed overflow with a one-cycle done pulse. It sits between client blocks and the adder datapath, so a narrow skip adder can serve wide additions.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived slice count; not overridable.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req0 / req1  input  1  level request; held high with operands stable until the matching gnt.
- a0, b0 / a1, b1  input  WIDTH  operands of requester 0 / 1.
- cin0 / cin1  input  1  carry-in of requester 0 / 1.
- gnt0 / gnt1  output  1  one-cycle pulse; operands captured on this edge.
- busy  output  1  high from the grant cycle until done, inclusive.
- done  output  1  one-cycle pulse; result valid.
- done_id  output  1  requester served by the current or last result.
- sum  output  WIDTH  registered result; held until the next done.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow: (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).

## Operation
- One internal `Carry_skip_adder` instance, port order (sum, carry, a, b, cin). Its inputs are operand nibble [4i+3:4i] and the carry register.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick the winner, pulse its gnt, latch its a, b and cin into the operand registers and carry register, set idx=0, go to RUN.
- Arbitration:
  - Only one request high: that requester wins.
  - Both high: the requester that is not last_id wins. last_id updates on grant.
- RUN, once per cycle:
  - Write the slice sum into result nibble idx.
  - Load the slice carry into the carry register.
  - idx++.
  - After the write of nibble NSLICE-1, go to DONE.
- DONE: load sum, cout and ovf from the internal result; pulse done; drive done_id; go to IDLE.
- Requests during RUN or DONE get no gnt. They stay pending and are arbitrated in the next IDLE cycle.
- A grant can issue in the cycle right after DONE, since the FSM is in IDLE again.
- Widths: the carry chain is exactly WIDTH bits plus cout. No saturation; wrap-around is modulo 2^WIDTH.

## Timing
- Grant edge is cycle T (gnt high, busy high).
- RUN occupies cycles T+1 … T+NSLICE.
- done is high at T+NSLICE+1. With WIDTH=16, done comes 5 cycles after gnt.
- Minimum request-to-request throughput is NSLICE+2 cycles.
- sum, cout, ovf and done_id change only on the done cycle.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - All outputs go to 0: gnt0, gnt1, busy, done, done_id, sum, cout, ovf.
  - last_id goes to 1, so requester 0 wins the first tie.
  - An in-flight operation is discarded with no done. Requesters must re-request.
- WIDTH=4: RUN lasts exactly one cycle and done comes at T+2.

## Test plan
- req0, a0=0x1234, b0=0x0FCD, cin0=0 → gnt0 pulse, then done 5 cycles later with sum=0x2201, cout=0, ovf=0, done_id=0.
- req1, a1=0xFFFF, b1=0x0001, cin1=0 → sum=0x0000, cout=1, ovf=0, done_id=1. Also: a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- req0 and req1 both held after reset → gnt0 first, gnt1 at the first IDLE cycle after done, sum/done_id matching each pair. A further simultaneous pair is served req0 first again.
- Toggle req1 during busy → no gnt1 until IDLE. busy stays high continuously from gnt to done inclusive.
- Assert rst two cycles into RUN → all outputs 0 immediately, no done pulse. A new req0 afterwards completes normally.
- Random sweep (WIDTH=16 and WIDTH=4) → every result equals a+b+cin, checked against a reference model, with latency exactly NSLICE+1 cycles after gnt.

Source files
------------

// File: rtl/csa_add_scheduler.sv
// Round-robin scheduler sharing one 4-bit carry-skip adder slice between two requesters.
// Wide operands are summed one nibble per cycle, LSB nibble first, with a registered ripple carry.

module Carry_skip_adder (
    output logic [3:0] sum_o,
    output logic       carry_o,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i
);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1, c2, c3, c4;

    assign p  = a_i ^ b_i;
    assign g  = a_i & b_i;
    assign c1 = g[0] | (p[0] & cin_i);
    assign c2 = g[1] | (p[1] & c1);
    assign c3 = g[2] | (p[2] & c2);
    assign c4 = g[3] | (p[3] & c3);

    assign sum_o   = p ^ {c3, c2, c1, cin_i};
    // Full-propagate group lets the incoming carry bypass the ripple chain.
    assign carry_o = (&p) ? cin_i : c4;
endmodule

module csa_add_scheduler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    input  logic             cin0_i,
    input  logic             cin1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_id_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned MSB    = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cy_q, cy_d, last_id_q, last_id_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d, busy_q, busy_d;
    logic               done_q, done_d, done_id_q, done_id_d;
    logic               cout_q, cout_d, ovf_q, ovf_d;
    logic [3:0]         s_sum;
    logic               s_carry;
    logic               pick1;

    Carry_skip_adder u_slice (
        .sum_o   (s_sum),
        .carry_o (s_carry),
        .a_i     (a_q[{idx_q, 2'b00} +: 4]),
        .b_i     (b_q[{idx_q, 2'b00} +: 4]),
        .cin_i   (cy_q)
    );

    // On a tie the requester not served last wins.
    assign pick1 = req1_i & (~req0_i | ~last_id_q);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cy_d      = cy_q;
        idx_d     = idx_q;
        last_id_d = last_id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req0_i || req1_i) begin
                    gnt0_d    = ~pick1;
                    gnt1_d    = pick1;
                    last_id_d = pick1;
                    a_d       = pick1 ? a1_i : a0_i;
                    b_d       = pick1 ? b1_i : b0_i;
                    cy_d      = pick1 ? cin1_i : cin0_i;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                res_d[{idx_q, 2'b00} +: 4] = s_sum;
                cy_d  = s_carry;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                sum_d     = res_q;
                cout_d    = cy_q;
                ovf_d     = (a_q[MSB] == b_q[MSB]) && (res_q[MSB] != a_q[MSB]);
                done_d    = 1'b1;
                done_id_d = last_id_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cy_q      <= 1'b0;
            idx_q     <= '0;
            last_id_q <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            cy_q      <= cy_d;
            idx_q     <= idx_d;
            last_id_q <= last_id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign gnt0_o    = gnt0_q;
    assign gnt1_o    = gnt1_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;
    assign sum_o     = sum_q;
    assign cout_o    = cout_q;
    assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_csa_add_scheduler.sv
// Directed and randomized checks of csa_add_scheduler at WIDTH=16 and WIDTH=4
// against an arithmetic reference model.

module tb_csa_add_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          ncmp = 0;
    int          nerr = 0;

    logic        req0, req1, cin0, cin1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, busy, done, done_id, cout, ovf;
    logic [15:0] sum;

    logic        n_req0, n_req1, n_cin0, n_cin1;
    logic [3:0]  n_a0, n_b0, n_a1, n_b1;
    logic        n_gnt0, n_gnt1, n_busy, n_done, n_done_id, n_cout, n_ovf;
    logic [3:0]  n_sum;

    always #5 clk = ~clk;

    csa_add_scheduler #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req0_i(req0), .req1_i(req1),
        .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1), .cin0_i(cin0), .cin1_i(cin1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .busy_o(busy), .done_o(done),
        .done_id_o(done_id), .sum_o(sum), .cout_o(cout), .ovf_o(ovf)
    );

    csa_add_scheduler #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .req0_i(n_req0), .req1_i(n_req1),
        .a0_i(n_a0), .b0_i(n_b0), .a1_i(n_a1), .b1_i(n_b1), .cin0_i(n_cin0), .cin1_i(n_cin1),
        .gnt0_o(n_gnt0), .gnt1_o(n_gnt1), .busy_o(n_busy), .done_o(n_done),
        .done_id_o(n_done_id), .sum_o(n_sum), .cout_o(n_cout), .ovf_o(n_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start16(input int id, input logic [15:0] a, input logic [15:0] b, input logic c);
        if (id == 0) begin a0 = a; b0 = b; cin0 = c; req0 = 1'b1; end
        else         begin a1 = a; b1 = b; cin1 = c; req1 = 1'b1; end
    endtask

    // Waits for a grant to requester id, then for done; checks latency, busy and the result.
    task automatic finish16(input int id, input logic [15:0] a, input logic [15:0] b, input logic c,
                            input int exp_gwait, input bit tog);
        logic [16:0] ref_sum;
        logic        ref_ovf;
        logic [15:0] prev_sum;
        int          gw;
        int          k;
        ref_sum = {1'b0, a} + {1'b0, b} + 17'(c);
        ref_ovf = (a[15] == b[15]) && (ref_sum[15] != a[15]);
        gw = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (gnt0 || gnt1) begin gw = i; break; end
        end
        chk("gnt_seen", 32'(gw != 0), 32'd1);
        if (exp_gwait != 0) chk("gnt_wait", 32'(gw), 32'(exp_gwait));
        chk("gnt_which", {30'd0, gnt1, gnt0}, (id == 0) ? 32'd1 : 32'd2);
        chk("busy_at_gnt", 32'(busy), 32'd1);
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
        prev_sum = sum;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            if (tog) req1 = ~req1;
            tick();
            chk("busy_hold", 32'(busy), 32'd1);
            chk("no_gnt_busy", {30'd0, gnt1, gnt0}, 32'd0);
            if (done) begin k = i; break; end
            chk("sum_stable", 32'(sum), 32'(prev_sum));
        end
        if (tog) req1 = 1'b0;
        chk("latency", 32'(k), 32'd5);
        chk("sum", 32'(sum), 32'(ref_sum[15:0]));
        chk("cout", 32'(cout), 32'(ref_sum[16]));
        chk("ovf", 32'(ovf), 32'(ref_ovf));
        chk("done_id", 32'(done_id), 32'(id));
    endtask

    task automatic serve4(input int id, input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] ref_sum;
        int         gw;
        int         k;
        ref_sum = {1'b0, a} + {1'b0, b} + 5'(c);
        if (id == 0) begin n_a0 = a; n_b0 = b; n_cin0 = c; n_req0 = 1'b1; end
        else         begin n_a1 = a; n_b1 = b; n_cin1 = c; n_req1 = 1'b1; end
        gw = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (n_gnt0 || n_gnt1) begin gw = i; break; end
        end
        chk("w4_gnt", {30'd0, n_gnt1, n_gnt0}, (id == 0) ? 32'd1 : 32'd2);
        n_req0 = 1'b0;
        n_req1 = 1'b0;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (n_done) begin k = i; break; end
        end
        chk("w4_latency", 32'(k), 32'd2);
        chk("w4_sum", 32'(n_sum), 32'(ref_sum[3:0]));
        chk("w4_cout", 32'(n_cout), 32'(ref_sum[4]));
        chk("w4_ovf", 32'(n_ovf), 32'((a[3] == b[3]) && (ref_sum[3] != a[3])));
        chk("w4_done_id", 32'(n_done_id), 32'(id));
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        int          rid;
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; cin0 = 0; cin1 = 0;
        n_req0 = 0; n_req1 = 0; n_a0 = 0; n_b0 = 0; n_a1 = 0; n_b1 = 0; n_cin0 = 0; n_cin1 = 0;
        tick(); tick();
        chk("rst_outputs", {24'd0, gnt0, gnt1, busy, done, done_id, cout, ovf, 1'b0}, 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        rst = 1'b0;
        tick();

        // Simultaneous requests right after reset: requester 0 first, then 1 immediately after done.
        start16(0, 16'h1111, 16'h2222, 1'b0);
        start16(1, 16'hF000, 16'h1000, 1'b1);
        finish16(0, 16'h1111, 16'h2222, 1'b0, 1, 1'b0);
        finish16(1, 16'hF000, 16'h1000, 1'b1, 1, 1'b0);
        start16(0, 16'h0005, 16'h0006, 1'b1);
        start16(1, 16'h8000, 16'h8000, 1'b0);
        finish16(0, 16'h0005, 16'h0006, 1'b1, 1, 1'b0);
        finish16(1, 16'h8000, 16'h8000, 1'b0, 1, 1'b0);

        start16(0, 16'h1234, 16'h0FCD, 1'b0);
        finish16(0, 16'h1234, 16'h0FCD, 1'b0, 1, 1'b0);
        start16(1, 16'hFFFF, 16'h0001, 1'b0);
        finish16(1, 16'hFFFF, 16'h0001, 1'b0, 1, 1'b0);
        start16(1, 16'h7FFF, 16'h0000, 1'b1);
        finish16(1, 16'h7FFF, 16'h0000, 1'b1, 1, 1'b0);

        // req1 toggling while busy must not be granted.
        a1 = 16'h0101; b1 = 16'h0202; cin1 = 1'b0;
        start16(0, 16'hABCD, 16'h5432, 1'b1);
        finish16(0, 16'hABCD, 16'h5432, 1'b1, 1, 1'b1);
        tick();
        chk("no_gnt_after_toggle", {30'd0, gnt1, gnt0}, 32'd0);

        // Reset two cycles into RUN discards the operation.
        start16(0, 16'h4444, 16'h3333, 1'b0);
        tick();
        chk("rst_test_gnt", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {24'd0, gnt0, gnt1, busy, done, done_id, cout, ovf, 1'b0}, 32'd0);
        chk("async_rst_sum", 32'(sum), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_done_after_rst", {30'd0, done, busy}, 32'd0);
        end
        start16(0, 16'h4444, 16'h3333, 1'b0);
        finish16(0, 16'h4444, 16'h3333, 1'b0, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rid = int'($urandom_range(1, 0));
            start16(rid, ra, rb, rc);
            finish16(rid, ra, rb, rc, 0, 1'b0);
        end

        serve4(0, 4'h7, 4'h1, 1'b0);
        serve4(1, 4'hF, 4'h1, 1'b0);
        for (int n = 0; n < 30; n++) begin
            serve4(int'($urandom_range(1, 0)), 4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
